// File: rtl/core_memory_initiator_if.sv
// Bundle of the core-side request/response channel and the Controller core memory port.
// slave is the initiator's view; master is the view of whatever drives it (core + Controller).
interface core_memory_initiator_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [BUS_WIDTH-1:0] req_address;
  logic [BUS_WIDTH-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [BUS_WIDTH-1:0] rsp_rdata;
  logic                 rsp_error;
  logic                 core_read_memory;
  logic                 core_write_memory;
  logic [BUS_WIDTH-1:0] core_address_memory;
  logic [BUS_WIDTH-1:0] core_write_data_memory;
  logic [BUS_WIDTH-1:0] core_read_data_memory;
  logic                 core_memory_response;
  logic                 stray_response;

  modport slave (
    input  req_valid, req_write, req_address, req_wdata, rsp_ready,
           core_read_data_memory, core_memory_response,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
           core_read_memory, core_write_memory, core_address_memory,
           core_write_data_memory, stray_response
  );

  modport master (
    output req_valid, req_write, req_address, req_wdata, rsp_ready,
           core_read_data_memory, core_memory_response,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
           core_read_memory, core_write_memory, core_address_memory,
           core_write_data_memory, stray_response
  );
endinterface

// File: rtl/core_memory_initiator.sv
// Single-outstanding core memory master: turns one valid/ready request into a held
// read/write strobe toward the Controller and returns data or a timeout error.
module core_memory_initiator #(
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                   clk,
  input logic                   reset,
  core_memory_initiator_if.slave bus
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        count_reg, count_next;
  logic [BUS_WIDTH-1:0] rdata_reg, rdata_next;
  logic                 error_reg, error_next;
  logic [BUS_WIDTH-1:0] address_reg, address_next;
  logic [BUS_WIDTH-1:0] wdata_reg, wdata_next;
  logic                 stray_reg, stray_next;
  logic                 strobe_active;
  logic                 timeout_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      rdata_reg   <= '0;
      error_reg   <= 1'b0;
      address_reg <= '0;
      wdata_reg   <= '0;
      stray_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      rdata_reg   <= rdata_next;
      error_reg   <= error_next;
      address_reg <= address_next;
      wdata_reg   <= wdata_next;
      stray_reg   <= stray_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    rdata_next    = rdata_reg;
    error_next    = error_reg;
    address_next  = address_reg;
    wdata_next    = wdata_reg;
    strobe_active = (state_reg == READ) || (state_reg == WRITE);
    timeout_hit   = (TIMEOUT_CYCLES != 0) && (count_reg == LAST_COUNT);
    // A response outside a strobe is flagged only; it never completes a later transaction.
    stray_next    = stray_reg | (bus.core_memory_response & ~strobe_active);

    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          address_next = bus.req_address;
          wdata_next   = bus.req_wdata;
          count_next   = '0;
          state_next   = bus.req_write ? WRITE : READ;
        end
      end
      READ, WRITE: begin
        if (bus.core_memory_response) begin
          state_next = RESP;
          error_next = 1'b0;
          rdata_next = (state_reg == READ) ? bus.core_read_data_memory : '0;
        end else if (timeout_hit) begin
          state_next = RESP;
          error_next = 1'b1;
          rdata_next = '0;
        end else begin
          count_next = count_reg + CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req_ready              = (state_reg == IDLE);
  assign bus.rsp_valid              = (state_reg == RESP);
  assign bus.rsp_rdata              = rdata_reg;
  assign bus.rsp_error              = error_reg;
  assign bus.core_read_memory       = (state_reg == READ);
  assign bus.core_write_memory      = (state_reg == WRITE);
  assign bus.core_address_memory    = address_reg;
  assign bus.core_write_data_memory = wdata_reg;
  assign bus.stray_response         = stray_reg;
endmodule

// File: doc/core_memory_initiator.md
# core_memory_initiator

Core-side master for the Controller's core memory port. Accepts single-beat read/write requests from a processor core over a valid/ready interface and drives the Controller's `core_read_memory`/`core_write_memory` strobes until `core_memory_response` arrives. Returns data or a timeout error on a valid/ready response channel. Sits between the core under test and the Controller, clocked on the same domain as the Controller port.

## Interface
- `BUS_WIDTH`, 32: address and data width.
- `TIMEOUT_CYCLES`, 1024: maximum strobe-high cycles before an error response; 0 disables the timeout.
- `clk`  in  1: clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: core request valid.
- `req_ready`  out  1: initiator can accept a request.
- `req_write`  in  1: 1 = write, 0 = read.
- `req_address`  in  BUS_WIDTH: request address.
- `req_wdata`  in  BUS_WIDTH: write data.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: core accepts the response.
- `rsp_rdata`  out  BUS_WIDTH: read data; 0 for writes and errors.
- `rsp_error`  out  1: transaction timed out.
- `core_read_memory`  out  1: read strobe to the Controller.
- `core_write_memory`  out  1: write strobe to the Controller.
- `core_address_memory`  out  BUS_WIDTH: address to the Controller.
- `core_write_data_memory`  out  BUS_WIDTH: write data to the Controller.
- `core_read_data_memory`  in  BUS_WIDTH: read data from the Controller.
- `core_memory_response`  in  1: Controller completion pulse or level.
- `stray_response`  out  1: sticky flag; a response was seen with no strobe active.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1, which is a decode of the state. On `req_valid && req_ready`:
  - latch address and data into `core_address_memory`/`core_write_data_memory`;
  - clear the timeout counter;
  - go to WRITE if `req_write`, else READ.
- READ/WRITE: the matching strobe is 1, driven from a registered state. Address and data are held stable.
  - If `core_memory_response` is sampled 1: drop the strobe and go to RESP with `rsp_error`=0.
  - READ latches `rsp_rdata` = `core_read_data_memory` in the same cycle. WRITE sets `rsp_rdata`=0.
- Timeout: the counter, of width clog2(TIMEOUT_CYCLES+1), increments on each strobe-high cycle without a response.
  - When it equals TIMEOUT_CYCLES-1 and no response is sampled: drop the strobe, set `rsp_error`=1 and `rsp_rdata`=0, go to RESP.
  - A response in the terminal cycle wins; `rsp_error`=0.
- RESP: `rsp_valid`=1, with `rsp_rdata`/`rsp_error` stable. On `rsp_ready`, go to IDLE and clear `rsp_valid`.
- `core_memory_response`=1 in IDLE or RESP sets `stray_response`, which is cleared only by reset. A response is never consumed as the completion of a later transaction.
- `core_address_memory`/`core_write_data_memory` keep the last request's value after completion.

## Timing
- Reset values, applied immediately and asynchronously: state IDLE; `req_ready`=1; `rsp_valid`=0; `rsp_error`=0; `rsp_rdata`=0; both strobes 0; address/data 0; counter 0; `stray_response`=0.
- Request accepted at edge N: strobe high from cycle N+1; `req_ready` low from N+1.
- Response sampled at the end of cycle M ≥ N+1: strobe low and `rsp_valid` high from M+1. The minimum request-to-response latency is 2 cycles.
- Timeout: the strobe is high for exactly TIMEOUT_CYCLES cycles; `rsp_valid` is 1 in the next cycle.
- `rsp_valid && rsp_ready` at edge K: `req_ready` high from K+1. At most one transaction is outstanding; there is no back-to-back acceptance in the RESP cycle.
- Reset mid-transaction aborts it with no response issued. A Controller response arriving after reset sets `stray_response`.
- `req_*` inputs are ignored outside IDLE.

## Test plan
- Read at 0x0000_0010; Controller responds 3 cycles after the strobe rises with 0xDEADBEEF -> `core_read_memory` high for 3 cycles, then `rsp_valid`=1, `rsp_rdata`=0xDEADBEEF, `rsp_error`=0.
- Write 0x1234_5678 to 0x0000_0020; response in the first strobe cycle -> `core_write_memory` high for 1 cycle, address/data stable, `rsp_valid` at accept+2, `rsp_rdata`=0.
- TIMEOUT_CYCLES=8, no response -> strobe high for exactly 8 cycles, then `rsp_error`=1, `rsp_rdata`=0; a response in cycle 8 instead gives `rsp_error`=0.
- `rsp_ready` held low for 5 cycles -> `rsp_valid`/`rsp_rdata` stable, `req_ready`=0, new `req_valid` ignored; `req_ready`=1 one cycle after the handshake.
- `core_memory_response` pulsed in IDLE -> `stray_response`=1 and stays 1; the next read still waits for its own response.
- Reset asserted mid-READ -> strobes and `rsp_valid` drop immediately, `req_ready`=1; a late response sets `stray_response`.
